// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port between instruction fetch (0)
// and load/store (1), sequencing each access through a fixed latency.
module mem_port_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [31:0] addr0,
    input  logic        req1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    input  logic        we1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] rdata,
    output logic        sel,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             owner;
    // on a tie the requester that did not win last time gets the port
    assign owner     = (req0 & req1) ? ~last : req1;
    assign mem_en    = state == BUSY;
    assign mem_we    = mem_en & sel & we1;
    assign mem_addr  = sel ? addr1 : addr0;
    assign mem_wdata = sel ? wdata1 : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            sel   <= 1'b0;
            rdata <= '0;
            cnt   <= '0;
            last  <= 1'b1;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: if (req0 | req1) begin
                    state <= BUSY;
                    sel   <= owner;
                    gnt0  <= ~owner;
                    gnt1  <= owner;
                    cnt   <= CNT_W'(MEM_LAT - 1);
                    last  <= owner;
                end
                BUSY: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        rdata <= mem_rdata;
                        state <= DONE;
                        done0 <= ~sel;
                        done1 <= sel;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 32-bit memory port between two requesters: requester 0 (instruction fetch) and requester 1 (load/store unit).
- Generates the select that drives the existing 2:1 32-bit mux on the memory address and write-data paths.
- Sequences each access through a fixed memory latency.
- Returns read data with a one-cycle done pulse to the granted requester.

Parameters:
- MEM_LAT, 2: memory access cycles per transfer; legal range 1..15.
- CNT_W, 4: width of the latency counter; must hold MEM_LAT.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req0  input  1  requester 0 access request, level
- addr0  input  32  requester 0 address
- req1  input  1  requester 1 access request, level
- addr1  input  32  requester 1 address
- wdata1  input  32  requester 1 write data
- we1  input  1  requester 1 write enable; requester 0 is read-only
- gnt0  output  1  requester 0 owns the port
- gnt1  output  1  requester 1 owns the port
- done0  output  1  one-cycle completion pulse to requester 0
- done1  output  1  one-cycle completion pulse to requester 1
- rdata  output  32  registered read data; valid while doneX=1
- sel  output  1  mux select: 0 = requester 0 path, 1 = requester 1 path
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write strobe
- mem_addr  output  32  muxed address
- mem_wdata  output  32  write data; wdata1 when sel=1, else 0
- mem_rdata  input  32  memory read data, valid on last access cycle

Behaviour:
- Reset: synchronous active-high; one clock, reset is fixed as decided.
  - On rst=1 at a rising edge: state=IDLE; gnt0=gnt1=done0=done1=mem_en=mem_we=0; sel=0; rdata=0; counter=0; last=1.
  - Reset mid-transfer aborts it: no done pulse is issued.
- States: IDLE, BUSY, DONE. All outputs are registered or decoded from registered state.
- IDLE:
  - If req0|req1, arbitrate, then go to BUSY.
  - Single request: grant that requester.
  - Both requesting: round-robin; grant the requester not equal to `last`. After reset, requester 0 wins the first tie.
  - On grant: latch owner into sel, set gntX=1, counter=MEM_LAT-1, last=owner.
  - No request: stay in IDLE, all strobes 0.
- BUSY:
  - mem_en=1; mem_we = we1 & sel.
  - mem_addr / mem_wdata follow the selected requester's inputs combinationally through the mux.
  - Counter decrements each cycle.
  - When counter==0, capture mem_rdata into rdata and go to DONE.
  - BUSY lasts exactly MEM_LAT cycles.
- DONE:
  - done[sel]=1 for exactly one cycle; gnt stays 1; mem_en=0; rdata holds the captured value.
  - Next state is IDLE; gnt drops.
  - For writes, rdata captures whatever mem_rdata shows; requesters ignore it.
- Latency: request seen in IDLE at edge t → gnt at t+1 → done at t+1+MEM_LAT. Throughput is one transfer per MEM_LAT+2 cycles.
- Requester rules:
  - Hold reqX, addrX, wdata1 and we1 stable from request until doneX.
  - Deasserting req while granted does not abort the transfer; it completes and done still pulses.
  - A req held high after done is treated as a new request in IDLE and competes by round-robin.
- Invariants:
  - gnt0 & gnt1 is never 1.
  - done asserts only for the current owner.
  - mem_we is never 1 when sel=0.
- rdata changes only on the capture edge or reset.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req0=req1=1 → all outputs 0, sel=0, no grant until the first IDLE cycle after release.
- Single read, MEM_LAT=2: req0=1, addr0=0x0000_0040, memory model returns 0xDEAD_BEEF → gnt0 rises 1 cycle later; mem_en high 2 cycles with mem_addr=0x40; done0 pulses with rdata=0xDEAD_BEEF; total 4 cycles.
- Write: req1=1, we1=1, addr1=0x100, wdata1=0x1234_5678 → sel=1; mem_we=1 for 2 cycles; mem_wdata=0x1234_5678; done1 pulses once; gnt0 stays 0.
- Contention, both held high for 4 transfers from reset → grant order 0,1,0,1; never both gnts high; each transfer 4 cycles apart.
- Early release: req0 drops 1 cycle after gnt0 → transfer still runs MEM_LAT cycles and done0 pulses.
- Reset mid-BUSY: assert rst on the 1st BUSY cycle → next cycle IDLE, mem_en=0, no done pulse, rdata=0.
